// File: rtl/vga_update_sequencer.sv
// vga_update_sequencer: streams one tear-free frame of BCD and control fields into the
// Control_VGA shadow-register ports, bracketed by a freeze (0x19=00) and a re-arm (0x19=FF).
module vga_update_sequencer #(
    parameter int GAP = 1
) (
    input  logic       reloj_nexys,
    input  logic       reset_interno,
    input  logic       req,
    input  logic       fin_crono_evt,
    input  logic [7:0] hora,
    input  logic [7:0] min,
    input  logic [7:0] seg,
    input  logic [7:0] dia,
    input  logic [7:0] mes,
    input  logic [7:0] anio,
    input  logic [7:0] hcrono,
    input  logic [7:0] mcrono,
    input  logic [7:0] scrono,
    input  logic [7:0] hrun,
    input  logic [7:0] mrun,
    input  logic [7:0] srun,
    input  logic       am_pm,
    input  logic       formato,
    input  logic [2:0] dir_cursor,
    input  logic [7:0] prog_lugar,
    output logic [7:0] id_port,
    output logic [7:0] dato,
    output logic       write_strobe,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FIN} state_t;

    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    state_t          r_state;
    logic [4:0]      r_idx;
    logic [GW-1:0]   r_gap;
    logic            r_req_pend, r_fin_pend, r_fin_now;
    logic [7:0]      r_hora, r_min, r_seg, r_dia, r_mes, r_anio;
    logic [7:0]      r_hcrono, r_mcrono, r_scrono, r_hrun, r_mrun, r_srun;
    logic            r_am_pm, r_formato;
    logic [2:0]      r_dir_cursor;
    logic [7:0]      r_prog_lugar;
    logic [7:0]      r_id_port, r_dato;
    logic            r_write_strobe, r_busy, r_done;

    logic [7:0]      w_next_port, w_next_dato;
    logic            w_trigger, w_step, w_last;

    // r_idx counts writes already issued; write 0 (freeze) is emitted on the trigger edge.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        w_next_port = 8'h00;
        w_next_dato = 8'h00;
        case (r_idx)
            5'd1:  begin w_next_port = 8'h04; w_next_dato = {4'h0, r_anio[7:4]};   end
            5'd2:  begin w_next_port = 8'h05; w_next_dato = {4'h0, r_anio[3:0]};   end
            5'd3:  begin w_next_port = 8'h06; w_next_dato = {4'h0, r_mes[7:4]};    end
            5'd4:  begin w_next_port = 8'h07; w_next_dato = {4'h0, r_mes[3:0]};    end
            5'd5:  begin w_next_port = 8'h08; w_next_dato = {4'h0, r_dia[7:4]};    end
            5'd6:  begin w_next_port = 8'h09; w_next_dato = {4'h0, r_dia[3:0]};    end
            5'd7:  begin w_next_port = 8'h0A; w_next_dato = {4'h0, r_hora[7:4]};   end
            5'd8:  begin w_next_port = 8'h0B; w_next_dato = {4'h0, r_hora[3:0]};   end
            5'd9:  begin w_next_port = 8'h0C; w_next_dato = {4'h0, r_min[7:4]};    end
            5'd10: begin w_next_port = 8'h0D; w_next_dato = {4'h0, r_min[3:0]};    end
            5'd11: begin w_next_port = 8'h0E; w_next_dato = {4'h0, r_seg[7:4]};    end
            5'd12: begin w_next_port = 8'h0F; w_next_dato = {4'h0, r_seg[3:0]};    end
            5'd13: begin w_next_port = 8'h10; w_next_dato = {4'h0, r_hrun[7:4]};   end
            5'd14: begin w_next_port = 8'h11; w_next_dato = {4'h0, r_hrun[3:0]};   end
            5'd15: begin w_next_port = 8'h12; w_next_dato = {4'h0, r_mrun[7:4]};   end
            5'd16: begin w_next_port = 8'h13; w_next_dato = {4'h0, r_mrun[3:0]};   end
            5'd17: begin w_next_port = 8'h14; w_next_dato = {4'h0, r_srun[7:4]};   end
            5'd18: begin w_next_port = 8'h15; w_next_dato = {4'h0, r_srun[3:0]};   end
            5'd19: begin w_next_port = 8'h16; w_next_dato = {3'b0, r_am_pm, 3'b0, r_formato}; end
            5'd20: begin w_next_port = 8'h17; w_next_dato = {5'b0, r_dir_cursor};  end
            5'd21: begin w_next_port = 8'h18; w_next_dato = r_prog_lugar;          end
            5'd22: begin w_next_port = 8'h1A; w_next_dato = {4'h0, r_hcrono[7:4]}; end
            5'd23: begin w_next_port = 8'h1B; w_next_dato = {4'h0, r_hcrono[3:0]}; end
            5'd24: begin w_next_port = 8'h1C; w_next_dato = {4'h0, r_mcrono[7:4]}; end
            5'd25: begin w_next_port = 8'h1D; w_next_dato = {4'h0, r_mcrono[3:0]}; end
            5'd26: begin w_next_port = 8'h1E; w_next_dato = {4'h0, r_scrono[7:4]}; end
            5'd27: begin w_next_port = 8'h1F; w_next_dato = {4'h0, r_scrono[3:0]}; end
            5'd28: begin
                w_next_port = r_fin_now ? 8'h20 : 8'h19;
                w_next_dato = r_fin_now ? 8'h00 : 8'hFF;
            end
            5'd29: begin w_next_port = 8'h19; w_next_dato = 8'hFF; end
            default: ;
        endcase
    end

    // FIN behaves like IDLE for triggering, so a pending request restarts on the edge ending FIN.
    assign w_trigger = ((r_state == S_IDLE) || (r_state == S_FIN)) &&
                       (req || r_req_pend || r_fin_pend || fin_crono_evt);
    assign w_step    = ((r_state == S_ISSUE) && (GAP == 0)) ||
                       ((r_state == S_WAIT) && (r_gap == GAP_LAST));
    assign w_last    = (r_idx == (r_fin_now ? 5'd30 : 5'd29));

    // NOTE: non-blocking assignments throughout so every register updates from pre-edge values.
    always_ff @(posedge reloj_nexys or posedge reset_interno) begin
        if (reset_interno) begin
            r_state        <= S_IDLE;
            r_idx          <= '0;
            r_gap          <= '0;
            r_req_pend     <= 1'b0;
            r_fin_pend     <= 1'b0;
            r_fin_now      <= 1'b0;
            r_hora         <= '0; r_min    <= '0; r_seg    <= '0;
            r_dia          <= '0; r_mes    <= '0; r_anio   <= '0;
            r_hcrono       <= '0; r_mcrono <= '0; r_scrono <= '0;
            r_hrun         <= '0; r_mrun   <= '0; r_srun   <= '0;
            r_am_pm        <= 1'b0;
            r_formato      <= 1'b0;
            r_dir_cursor   <= '0;
            r_prog_lugar   <= '0;
            r_id_port      <= '0;
            r_dato         <= '0;
            r_write_strobe <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_write_strobe <= 1'b0;
            r_id_port      <= 8'h00;
            r_dato         <= 8'h00;
            r_done         <= 1'b0;

            case (r_state)
                S_IDLE, S_FIN: begin
                    r_state <= S_IDLE;
                    if (w_trigger) begin
                        r_hora   <= hora;   r_min    <= min;    r_seg    <= seg;
                        r_dia    <= dia;    r_mes    <= mes;    r_anio   <= anio;
                        r_hcrono <= hcrono; r_mcrono <= mcrono; r_scrono <= scrono;
                        r_hrun   <= hrun;   r_mrun   <= mrun;   r_srun   <= srun;
                        r_am_pm      <= am_pm;
                        r_formato    <= formato;
                        r_dir_cursor <= dir_cursor;
                        r_prog_lugar <= prog_lugar;
                        r_fin_now      <= r_fin_pend | fin_crono_evt;
                        r_fin_pend     <= 1'b0;
                        r_req_pend     <= 1'b0;
                        r_busy         <= 1'b1;
                        r_write_strobe <= 1'b1;
                        r_id_port      <= 8'h19;
                        r_dato         <= 8'h00;
                        r_idx          <= 5'd1;
                        r_state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (GAP > 0) begin
                        r_gap   <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_gap != GAP_LAST) r_gap <= r_gap + GW'(1);
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_step) begin
                if (w_last) begin
                    r_state <= S_FIN;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                end else begin
                    r_state        <= S_ISSUE;
                    r_write_strobe <= 1'b1;
                    r_id_port      <= w_next_port;
                    r_dato         <= w_next_dato;
                    r_idx          <= r_idx + 5'd1;
                end
            end

            // Requests arriving mid-sequence collapse into one pending trigger each.
            if ((r_state == S_ISSUE) || (r_state == S_WAIT)) begin
                if (req)           r_req_pend <= 1'b1;
                if (fin_crono_evt) r_fin_pend <= 1'b1;
            end
        end
    end

    assign id_port      = r_id_port;
    assign dato         = r_dato;
    assign write_strobe = r_write_strobe;
    assign busy         = r_busy;
    assign done         = r_done;
endmodule
